// File: rtl/ps2_keycode_source_if.sv
// Keycode bus between the PS/2 receiver and its consumers, plus the raw PS/2 pins it samples.
interface ps2_keycode_source_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       keycode_chg;
    logic       frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output keycode,
        output keycode_chg,
        output frame_err
    );

    modport slave (
        input keycode,
        input keycode_chg,
        input frame_err
    );
endinterface

// File: rtl/ps2_keycode_source.sv
// PS/2 set-2 receiver that maps game keys to HID usage codes on an 8-bit keycode bus.
// Optional macro PS2_PARITY_CHECK_EN: reject frames whose data+parity popcount is even.
module ps2_keycode_source #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic Clk,
    input  logic Reset,
    ps2_keycode_source_if.master bus
);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic       clk_s1_q, clk_s2_q, clk_prev_q;
    logic       dat_s1_q, dat_s2_q;
    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic [7:0] keycode_q, keycode_d;
    logic       chg_q, chg_d;
    logic       err_q, err_d;
    logic       fall;
    logic       parity_ok;
    logic       map_hit;
    logic [7:0] map_code;

`ifdef PS2_PARITY_CHECK_EN
    logic par_q, par_d;
    assign parity_ok = ^{shift_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    assign fall = clk_prev_q & ~clk_s2_q;

    always_comb begin
        map_hit  = 1'b1;
        map_code = 8'h00;
        case (shift_q)
            8'h1C:   map_code = 8'h04;
            8'h23:   map_code = 8'h07;
            8'h1B:   map_code = 8'h16;
            8'h1D:   map_code = 8'h1A;
            8'h29:   map_code = 8'h2C;
            default: map_hit  = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        keycode_d = keycode_q;
        chg_d     = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = dat_s2_q;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_s2_q && parity_ok) begin
                        if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else begin
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                            // Extended keys are never game keys, so E0-prefixed bytes are dropped.
                            if (!ext_q && map_hit) begin
                                if (brk_q) begin
                                    if (keycode_q == map_code) begin
                                        keycode_d = 8'h00;
                                        chg_d     = 1'b1;
                                    end
                                end else if (keycode_q != map_code) begin
                                    keycode_d = map_code;
                                    chg_d     = 1'b1;
                                end
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            // Synchronisers reset to the idle-high line level so no false fall follows reset.
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            tmo_q      <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            keycode_q  <= 8'h00;
            chg_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q      <= 1'b0;
`endif
        end else begin
            clk_s1_q   <= bus.ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= bus.ps2_data;
            dat_s2_q   <= dat_s1_q;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            keycode_q  <= keycode_d;
            chg_q      <= chg_d;
            err_q      <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q      <= par_d;
`endif
        end
    end

    assign bus.keycode     = keycode_q;
    assign bus.keycode_chg = chg_q;
    assign bus.frame_err   = err_q;
endmodule

// File: tb/tb_ps2_keycode_source.sv
// Directed bench for ps2_keycode_source: frames are bit-banged onto the PS/2 pins.
module tb_ps2_keycode_source;
    localparam int TMO = 300;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_keycode_source_if bus();

    ps2_keycode_source #(.TIMEOUT_CYC(TMO)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int chg_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (bus.keycode_chg === 1'b1) chg_cnt++;
        if (bus.frame_err === 1'b1) err_cnt++;
        if (bus.keycode_chg === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
    end

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (6) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop_v);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_good ? ~^b : ^b);
        ps2_bit(stop_v);
        repeat (2) @(negedge clk);
        #1;
        $display("frame %02h par_ok=%0b stop=%0b -> keycode=%02h chg_total=%0d err_total=%0d",
                 b, par_good, stop_v, bus.keycode, chg_cnt, err_cnt);
    endtask

    task automatic test_reset;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL reset_keycode got=%h exp=00", bus.keycode); end
        checks++; if (bus.keycode_chg !== 1'b0) begin failures++; $display("FAIL reset_chg got=%b exp=0", bus.keycode_chg); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.frame_err); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_make_latency;
        logic [3:0] obs;
        logic [7:0] b;
        int c0, e0;
        c0 = chg_cnt; e0 = err_cnt;
        b = 8'h1D;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b0;
        obs = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            obs[k] = bus.keycode_chg;
        end
        repeat (2) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        $display("frame 1d (latency probe) -> keycode=%02h chg_pattern=%b", bus.keycode, obs);
        checks++; if (obs !== 4'b0100) begin failures++; $display("FAIL make_latency got=%b exp=0100", obs); end
        checks++; if (bus.keycode !== 8'h1A) begin failures++; $display("FAIL make_keycode got=%h exp=1a", bus.keycode); end
        checks++; if (chg_cnt - c0 !== 1) begin failures++; $display("FAIL make_chg_count got=%0d exp=1", chg_cnt - c0); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL make_err_count got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_break;
        int c0;
        c0 = chg_cnt;
        send_frame(8'hF0, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h1A) begin failures++; $display("FAIL break_prefix_keycode got=%h exp=1a", bus.keycode); end
        checks++; if (chg_cnt - c0 !== 0) begin failures++; $display("FAIL break_prefix_chg got=%0d exp=0", chg_cnt - c0); end
        send_frame(8'h1D, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL break_keycode got=%h exp=00", bus.keycode); end
        checks++; if (chg_cnt - c0 !== 1) begin failures++; $display("FAIL break_chg got=%0d exp=1", chg_cnt - c0); end
    endtask

    task automatic test_override_typematic;
        int c0;
        c0 = chg_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h04) begin failures++; $display("FAIL override_a got=%h exp=04", bus.keycode); end
        send_frame(8'h23, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h07) begin failures++; $display("FAIL override_d got=%h exp=07", bus.keycode); end
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h07) begin failures++; $display("FAIL stale_break got=%h exp=07", bus.keycode); end
        checks++; if (chg_cnt - c0 !== 2) begin failures++; $display("FAIL override_chg got=%0d exp=2", chg_cnt - c0); end
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h23, 1'b1, 1'b1);
        c0 = chg_cnt;
        for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h04) begin failures++; $display("FAIL typematic_keycode got=%h exp=04", bus.keycode); end
        checks++; if (chg_cnt - c0 !== 1) begin failures++; $display("FAIL typematic_chg got=%0d exp=1", chg_cnt - c0); end
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL typematic_release got=%h exp=00", bus.keycode); end
    endtask

    task automatic test_extended;
        int c0;
        c0 = chg_cnt;
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL ext_keycode got=%h exp=00", bus.keycode); end
        checks++; if (chg_cnt - c0 !== 0) begin failures++; $display("FAIL ext_chg got=%0d exp=0", chg_cnt - c0); end
        send_frame(8'h29, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h2C) begin failures++; $display("FAIL ext_then_space got=%h exp=2c", bus.keycode); end
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h29, 1'b1, 1'b1);
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        repeat (TMO + 20) @(negedge clk);
        #1;
        $display("partial frame abandoned -> err_total=%0d", err_cnt);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL timeout_keycode got=%h exp=00", bus.keycode); end
        send_frame(8'h1B, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h16) begin failures++; $display("FAIL after_timeout got=%h exp=16", bus.keycode); end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL after_timeout_err got=%0d exp=1", err_cnt - e0); end
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1B, 1'b1, 1'b1);
    endtask

    task automatic test_bad_stop;
        int c0, e0;
        c0 = chg_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL bad_stop_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (chg_cnt - c0 !== 0) begin failures++; $display("FAIL bad_stop_chg got=%0d exp=0", chg_cnt - c0); end
        checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL bad_stop_keycode got=%h exp=00", bus.keycode); end
    endtask

    task automatic test_parity;
        int e0;
        e0 = err_cnt;
        send_frame(8'h1D, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL parity_keycode got=%h exp=00", bus.keycode); end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL parity_err got=%0d exp=1", err_cnt - e0); end
`else
        checks++; if (bus.keycode !== 8'h1A) begin failures++; $display("FAIL parity_keycode got=%h exp=1a", bus.keycode); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL parity_err got=%0d exp=0", err_cnt - e0); end
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1D, 1'b1, 1'b1);
`endif
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = chg_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1D, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h1A) begin failures++; $display("FAIL b2b_keycode got=%h exp=1a", bus.keycode); end
        checks++; if (chg_cnt - c0 !== 2) begin failures++; $display("FAIL b2b_chg got=%0d exp=2", chg_cnt - c0); end
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1D, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL b2b_release got=%h exp=00", bus.keycode); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        int e0;
        send_frame(8'h23, 1'b1, 1'b1);
        e0 = err_cnt;
        b = 8'h1D;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        bus.ps2_data = b[4];
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("reset during bit 5 -> keycode=%02h chg=%b err=%b", bus.keycode, bus.keycode_chg, bus.frame_err);
        checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL midreset_keycode got=%h exp=00", bus.keycode); end
        checks++; if (bus.keycode_chg !== 1'b0) begin failures++; $display("FAIL midreset_chg got=%b exp=0", bus.keycode_chg); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL midreset_err_out got=%b exp=0", bus.frame_err); end
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst_n = 1'b1;
        repeat (TMO + 20) @(negedge clk);
        #1;
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL midreset_err_count got=%0d exp=0", err_cnt - e0); end
        send_frame(8'h1D, 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h1A) begin failures++; $display("FAIL after_midreset got=%h exp=1a", bus.keycode); end
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        @(negedge clk);
        test_reset;
        test_make_latency;
        test_break;
        test_override_typematic;
        test_extended;
        test_timeout;
        test_bad_stop;
        test_parity;
        test_back_to_back;
        test_reset_mid_frame;
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL chg_err_overlap got=%0d exp=0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
